// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
// State codes and port indices used by the RTL and the bench.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic CPU_PORT = 1'b0;
   localparam logic DBG_PORT = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, response and memory-side signals of the arbiter.
// slave is the arbiter side; master is the requesters/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              req0;
   logic              req1;
   logic              we0;
   logic              we1;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic              gnt0;
   logic              gnt1;
   logic              ack0;
   logic              ack1;
   logic [DATA_W-1:0] rdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  req0, req1, we0, we1,
      input  addr0, addr1, wdata0, wdata1,
      input  mem_rdata,
      output gnt0, gnt1, ack0, ack1, rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output req0, req1, we0, we1,
      output addr0, addr1, wdata0, wdata1,
      output mem_rdata,
      input  gnt0, gnt1, ack0, ack1, rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the port not served
// last wins; a lone requester always wins.
module rr_pick2
   import mem_port_arbiter_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic valid,
   output logic sel
);

   always_comb begin
      valid = req0 | req1;
      sel   = CPU_PORT;
      if (req0 && req1)
         sel = ~last;
      else if (req1)
         sel = DBG_PORT;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU controller and the
// debug/loader port with fixed-length, fully registered accesses.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst,
   mem_port_arbiter_if.slave  bus
);

   localparam logic [2:0] WMAX = 3'(WAIT_CYCLES);

   state_t            state, state_n;
   logic [2:0]        wcnt, wcnt_n;
   logic              last, last_n;
   logic              sel, sel_n;
   logic              we_l, we_n;
   logic [ADDR_W-1:0] addr_l, addr_n;
   logic [DATA_W-1:0] wdata_l, wdata_n;
   logic [DATA_W-1:0] rdata_q, rdata_n;
   logic              gnt0_q, gnt1_q;
   logic              ack0_q, ack1_q;
   logic              rd_q, wr_q;
   logic              pick_valid, pick_sel;

   rr_pick2 u_pick (
      .req0  (bus.req0),
      .req1  (bus.req1),
      .last  (last),
      .valid (pick_valid),
      .sel   (pick_sel)
   );

   always_comb begin
      state_n = state;
      wcnt_n  = wcnt;
      last_n  = last;
      sel_n   = sel;
      we_n    = we_l;
      addr_n  = addr_l;
      wdata_n = wdata_l;
      rdata_n = rdata_q;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               sel_n   = pick_sel;
               we_n    = pick_sel ? bus.we1 : bus.we0;
               addr_n  = pick_sel ? bus.addr1 : bus.addr0;
               wdata_n = pick_sel ? bus.wdata1 : bus.wdata0;
               wcnt_n  = '0;
               state_n = ACCESS;
            end
         end
         ACCESS: begin
            if (wcnt == WMAX) begin
               if (!we_l)
                  rdata_n = bus.mem_rdata;
               state_n = DONE;
            end else begin
               wcnt_n = wcnt + 3'd1;
            end
         end
         DONE: begin
            last_n  = sel;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Outputs are decoded from next-state so they are pure flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         wcnt    <= '0;
         last    <= 1'b1;
         sel     <= CPU_PORT;
         we_l    <= 1'b0;
         addr_l  <= '0;
         wdata_l <= '0;
         rdata_q <= '0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state   <= state_n;
         wcnt    <= wcnt_n;
         last    <= last_n;
         sel     <= sel_n;
         we_l    <= we_n;
         addr_l  <= addr_n;
         wdata_l <= wdata_n;
         rdata_q <= rdata_n;
         gnt0_q  <= (state_n != IDLE) && (sel_n == CPU_PORT);
         gnt1_q  <= (state_n != IDLE) && (sel_n == DBG_PORT);
         ack0_q  <= (state_n == DONE) && (sel_n == CPU_PORT);
         ack1_q  <= (state_n == DONE) && (sel_n == DBG_PORT);
         rd_q    <= (state_n == ACCESS) && !we_n;
         wr_q    <= (state_n == ACCESS) && we_n;
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.ack0      = ack0_q;
   assign bus.ack1      = ack1_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;
   assign bus.mem_addr  = addr_l;
   assign bus.mem_wdata = wdata_l;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected acks are queued by
// the stimulus and checked by a negedge monitor; extra builds probe WAIT_CYCLES.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   typedef struct {
      logic        port;
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sbq[$];

   int          st_n;
   logic        seen_rd, seen_wr, ovl;
   logic [15:0] s_addr, s_wdata;

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b1 ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b0 ();
   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b7 ();

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1))
      u1 (.clk(clk), .rst(rst), .bus(b1.slave));
   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0))
      u0 (.clk(clk), .rst(rst), .bus(b0.slave));
   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(7))
      u7 (.clk(clk), .rst(rst), .bus(b7.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [15:0] mem_model(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
   endfunction

   assign b1.mem_rdata = mem_model(b1.mem_addr);
   assign b0.mem_rdata = mem_model(b0.mem_addr);
   assign b7.mem_rdata = mem_model(b7.mem_addr);

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic p, input logic w,
                       input logic [15:0] a, input logic [15:0] wd,
                       input logic [15:0] rd, input int cy);
      exp_t e;
      e.port  = p;
      e.we    = w;
      e.addr  = a;
      e.wdata = wd;
      e.rdata = rd;
      e.cyc   = cy;
      sbq.push_back(e);
   endtask

   initial begin
      st_n = 0; seen_rd = 0; seen_wr = 0; ovl = 0;
      s_addr = '0; s_wdata = '0;
   end

   // Monitor: collects strobe activity, checks each ack against the queue.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         st_n = 0; seen_rd = 0; seen_wr = 0; ovl = 0;
      end else begin
         if ((b1.gnt0 && b1.gnt1) || (b1.ack0 && b1.ack1))
            ovl = 1;
         if ((b1.mem_rd || b1.mem_wr) && !(b1.gnt0 || b1.gnt1))
            ovl = 1;
         if (b1.mem_rd || b1.mem_wr) begin
            st_n++;
            seen_rd = seen_rd | b1.mem_rd;
            seen_wr = seen_wr | b1.mem_wr;
            s_addr  = b1.mem_addr;
            s_wdata = b1.mem_wdata;
         end
         if (b1.ack0 || b1.ack1) begin
            chk("ack_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk("ack_port", b1.ack1, e.port);
               chk("ack_cycle", cyc, e.cyc);
               chk("strobe_len", st_n, 2);
               chk("mem_addr", s_addr, e.addr);
               chk("strobe_dir", {seen_wr, seen_rd},
                   e.we ? 2'b10 : 2'b01);
               if (e.we)
                  chk("mem_wdata", s_wdata, e.wdata);
               chk("rdata", b1.rdata, e.rdata);
               chk("exclusive", ovl, 0);
               chk("gnt_at_ack", {b1.gnt1, b1.gnt0},
                   e.port ? 2'b10 : 2'b01);
            end
            st_n = 0; seen_rd = 0; seen_wr = 0; ovl = 0;
         end
      end
   end

   initial begin
      int c, n0, n7, a0, a7, k0, k7;
      rst = 1'b1;
      b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
      b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
      b0.req0 = 0; b0.req1 = 0; b0.we0 = 0; b0.we1 = 0;
      b0.addr0 = '0; b0.addr1 = '0; b0.wdata0 = '0; b0.wdata1 = '0;
      b7.req0 = 0; b7.req1 = 0; b7.we0 = 0; b7.we1 = 0;
      b7.addr0 = '0; b7.addr1 = '0; b7.wdata0 = '0; b7.wdata1 = '0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("reset_state", {b1.gnt0, b1.gnt1, b1.ack0, b1.ack1,
          b1.mem_rd, b1.mem_wr, b1.mem_addr, b1.mem_wdata, b1.rdata}, 0);

      // tie out of reset: 0,1,0,1
      @(posedge clk); #2; c = cyc;
      b1.req0 = 1; b1.we0 = 0; b1.addr0 = 16'h0100;
      b1.req1 = 1; b1.we1 = 1; b1.addr1 = 16'h0200; b1.wdata1 = 16'hCAFE;
      push(CPU_PORT, 0, 16'h0100, 16'h0000, 16'h5B5A, c + 3);
      push(DBG_PORT, 1, 16'h0200, 16'hCAFE, 16'h5B5A, c + 7);
      push(CPU_PORT, 0, 16'h0100, 16'h0000, 16'h5B5A, c + 11);
      push(DBG_PORT, 1, 16'h0200, 16'hCAFE, 16'h5B5A, c + 15);
      repeat (15) @(posedge clk);
      #2; b1.req0 = 0; b1.req1 = 0;
      repeat (3) @(posedge clk);

      // single read, port 0
      #2; c = cyc;
      b1.req0 = 1; b1.we0 = 0; b1.addr0 = 16'h0010;
      push(CPU_PORT, 0, 16'h0010, 16'h0000, 16'hBEEF, c + 3);
      repeat (3) @(posedge clk);
      #2; b1.req0 = 0;
      repeat (3) @(posedge clk);

      // single write, port 1
      #2; c = cyc;
      b1.req1 = 1; b1.we1 = 1; b1.addr1 = 16'h00FF; b1.wdata1 = 16'h1234;
      push(DBG_PORT, 1, 16'h00FF, 16'h1234, 16'hBEEF, c + 3);
      repeat (3) @(posedge clk);
      #2; b1.req1 = 0;
      repeat (3) @(posedge clk);

      // early req drop and address change after grant
      #2; c = cyc;
      b1.req0 = 1; b1.we0 = 0; b1.addr0 = 16'h0020;
      push(CPU_PORT, 0, 16'h0020, 16'h0000, 16'h5A7A, c + 3);
      repeat (2) @(posedge clk);
      #2; b1.req0 = 0; b1.addr0 = 16'h0FFF;
      repeat (8) @(posedge clk);

      // reset during a port 1 write
      #2;
      b1.req1 = 1; b1.we1 = 1; b1.addr1 = 16'h0AAA; b1.wdata1 = 16'h7777;
      @(posedge clk); #2;
      rst = 1'b1; b1.req1 = 0;
      @(posedge clk); #1;
      chk("reset_mid", {b1.gnt0, b1.gnt1, b1.ack0, b1.ack1,
          b1.mem_rd, b1.mem_wr, b1.mem_addr, b1.mem_wdata, b1.rdata}, 0);
      #1 rst = 1'b0;

      // tie after reset goes to port 0
      @(posedge clk); #2; c = cyc;
      b1.req0 = 1; b1.we0 = 0; b1.addr0 = 16'h0030;
      b1.req1 = 1; b1.we1 = 0; b1.addr1 = 16'h0040;
      push(CPU_PORT, 0, 16'h0030, 16'h0000, 16'h5A6A, c + 3);
      push(DBG_PORT, 0, 16'h0040, 16'h0000, 16'h5A1A, c + 7);
      repeat (7) @(posedge clk);
      #2; b1.req0 = 0; b1.req1 = 0;
      repeat (4) @(posedge clk);

      // WAIT_CYCLES = 0 and 7 builds
      #2;
      b0.req0 = 1; b0.addr0 = 16'h0010;
      b7.req0 = 1; b7.addr0 = 16'h0010;
      n0 = 0; n7 = 0; a0 = -1; a7 = -1; k0 = 0; k7 = 0;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk); #2;
         if (k == 2) b0.req0 = 0;
         if (k == 9) b7.req0 = 0;
         @(negedge clk);
         if (b0.mem_rd) n0++;
         if (b7.mem_rd) n7++;
         if (b0.ack0) begin k0++; a0 = k; end
         if (b7.ack0) begin k7++; a7 = k; end
      end
      chk("w0_strobe", n0, 1);
      chk("w0_latency", a0, 2);
      chk("w0_acks", k0, 1);
      chk("w0_rdata", b0.rdata, 16'hBEEF);
      chk("w7_strobe", n7, 8);
      chk("w7_latency", a7, 9);
      chk("w7_acks", k7, 1);
      chk("w7_rdata", b7.rdata, 16'hBEEF);

      repeat (3) @(posedge clk);
      chk("sb_drained", sbq.size(), 0);
      chk("no_stray_strobe", st_n, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
